// File: rtl/id_hazard_ctrl_pkg.sv
// id_hazard_ctrl_pkg: shared constants and types for the lagartoII decode-stage sequencer.
// Contents:
//   OP_*      opcode encodings that carry source operands or mark a load
//   *_LSB     bit positions of the rs1/rs2/rd register fields
//   NOP_INSTR addi x0,x0,0, the IF/ID register value while empty after reset
//   state_e   sequencer state, also exported on the debug port
package id_hazard_ctrl_pkg;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;
endpackage

// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if: fetch / decode / execute handshake bundle around the decode sequencer.
// Signals (directions as seen by the sequencer, i.e. the slave modport):
//   if_valid_i, if_instr_i   fetch offers an instruction
//   if_ready_o               IF/ID can accept; doubles as the PC-advance enable
//   id_instr_o, id_valid_o   IF/ID instruction register and its valid bit
//   ex_ready_i, ex_issue_o   ID/EX may load / ID->EX transfer this cycle
//   branch_taken_i           one-cycle redirect pulse from EX
//   state_o                  sequencer state for debug
interface id_hazard_ctrl_if;
    import id_hazard_ctrl_pkg::*;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic        if_ready_o;
    logic [31:0] id_instr_o;
    logic        id_valid_o;
    logic        ex_ready_i;
    logic        ex_issue_o;
    logic        branch_taken_i;
    state_e      state_o;

    modport master (
        output if_valid_i, if_instr_i, ex_ready_i, branch_taken_i,
        input  if_ready_o, id_instr_o, id_valid_o, ex_issue_o, state_o
    );

    modport slave (
        input  if_valid_i, if_instr_i, ex_ready_i, branch_taken_i,
        output if_ready_o, id_instr_o, id_valid_o, ex_issue_o, state_o
    );
endinterface

// File: rtl/id_operand_use.sv
// id_operand_use: combinational decode of which source registers an instruction reads.
// Ports:
//   instr_i     in   32  instruction in the IF/ID register
//   uses_rs1_o  out  1   instruction reads rs1
//   uses_rs2_o  out  1   instruction reads rs2
//   is_load_o   out  1   instruction is a load
//   rs1_o/rs2_o/rd_o out 5 raw register fields
module id_operand_use
    import id_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        is_load_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);
    logic [6:0] op;
    logic       unused_bits;

    assign op         = instr_i[6:0];
    assign uses_rs2_o = op inside {OP_R, OP_S, OP_B};
    assign uses_rs1_o = uses_rs2_o | (op inside {OP_I, OP_L, OP_JALR});
    assign is_load_o  = op == OP_L;
    assign rs1_o      = instr_i[RS1_LSB +: 5];
    assign rs2_o      = instr_i[RS2_LSB +: 5];
    assign rd_o       = instr_i[RD_LSB +: 5];
    // funct3/funct7 play no part in operand usage
    assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: lagartoII decode-stage sequencer (IF/ID register, load-use stall, branch flush).
// Ports:
//   clk_i    in  1  clock, rising edge
//   rst_ni   in  1  asynchronous active-low reset
//   bus      slave modport of id_hazard_ctrl_if (fetch handshake, IF/ID register,
//            ID/EX issue, branch redirect, debug state)
// Parameters:
//   LOAD_LATENCY    bubbles per load-use hazard (>=1)
//   BRANCH_PENALTY  fetch cycles discarded after a taken branch (>=1)
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_LATENCY   = 1,
    parameter int BRANCH_PENALTY = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    id_hazard_ctrl_if.slave bus
);
    localparam int MAX_CNT = LOAD_LATENCY > BRANCH_PENALTY ? LOAD_LATENCY : BRANCH_PENALTY;
    localparam int CW      = $clog2(MAX_CNT + 1);
    // The first stall/flush cycle is spent in RUN (stall) or on the branch edge itself,
    // so the counter only has to cover the remaining N-1 cycles.
    localparam logic [CW-1:0] LSTALL_CNT = CW'(LOAD_LATENCY > 1 ? LOAD_LATENCY - 2 : 0);
    localparam logic [CW-1:0] FLUSH_CNT  = CW'(BRANCH_PENALTY > 1 ? BRANCH_PENALTY - 2 : 0);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            id_valid_q, id_valid_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_load_q, ex_load_d;

    logic            uses_rs1, uses_rs2, is_load;
    logic [4:0]      rs1, rs2, rd;
    logic            hazard, issue, if_ready, capture, branch;

    id_operand_use u_use (
        .instr_i    (id_instr_q),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .is_load_o  (is_load),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .rd_o       (rd)
    );

    assign branch   = bus.branch_taken_i;
    assign hazard   = id_valid_q & ex_load_q & (ex_rd_q != 5'd0) &
                      ((uses_rs1 & (rs1 == ex_rd_q)) | (uses_rs2 & (rs2 == ex_rd_q)));
    assign issue    = id_valid_q & bus.ex_ready_i & (state_q == ST_RUN) & ~hazard & ~branch;
    assign if_ready = state_q == ST_RUN ? ~id_valid_q | issue : state_q == ST_FLUSH;
    // In FLUSH the fetch is acknowledged (PC advances) but the instruction is discarded.
    assign capture  = bus.if_valid_i & if_ready & (state_q != ST_FLUSH) & ~branch;

    always_comb begin
        id_instr_d = capture ? bus.if_instr_i : id_instr_q;
        id_valid_d = branch ? 1'b0 : capture ? 1'b1 : issue ? 1'b0 : id_valid_q;
        ex_rd_d    = issue ? rd : ex_rd_q;
        // A bubble entering EX (or the squashed branch shadow) can never be a load.
        ex_load_d  = branch ? 1'b0 : issue ? is_load : bus.ex_ready_i ? 1'b0 : ex_load_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (branch) begin
            state_d = BRANCH_PENALTY > 1 ? ST_FLUSH : ST_RUN;
            cnt_d   = FLUSH_CNT;
        end else if (state_q == ST_RUN) begin
            state_d = hazard && LOAD_LATENCY > 1 ? ST_LSTALL : ST_RUN;
            cnt_d   = hazard && LOAD_LATENCY > 1 ? LSTALL_CNT : cnt_q;
        end else begin
            state_d = cnt_q == '0 ? ST_RUN : state_q;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            ex_rd_q    <= 5'd0;
            ex_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_load_q  <= ex_load_d;
        end
    end

    assign bus.if_ready_o = if_ready;
    assign bus.ex_issue_o = issue;
    assign bus.id_instr_o = id_instr_q;
    assign bus.id_valid_o = id_valid_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed bench for id_hazard_ctrl (u_a: LOAD_LATENCY=1/BRANCH_PENALTY=1, u_b: 3/2).
module tb_id_hazard_ctrl;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LW5   = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD   = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] LW0   = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD00 = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] ADDI5 = 32'h0053_8313; // addi x6,x7,5 (rs2 field = 5)

    logic [31:0] addi [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl_if ifa ();
    id_hazard_ctrl_if ifb ();

    id_hazard_ctrl #(.LOAD_LATENCY(1), .BRANCH_PENALTY(1)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    id_hazard_ctrl #(.LOAD_LATENCY(3), .BRANCH_PENALTY(2)) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Feed a then b back to back into u_a; b stalls one cycle when stall=1.
    task automatic pair_a(input string tag, input logic [31:0] a, input logic [31:0] b, input logic stall);
        ifa.if_valid_i = 1'b1;
        ifa.if_instr_i = a;
        tick;
        ifa.if_instr_i = b;
        #1;
        chk({tag, "_a_issue"}, 32'(ifa.ex_issue_o), 1);
        tick;
        ifa.if_valid_i = 1'b0;
        #1;
        chk({tag, "_b_instr"}, ifa.id_instr_o, b);
        chk({tag, "_b_issue"}, 32'(ifa.ex_issue_o), 32'(!stall));
        chk({tag, "_b_ifready"}, 32'(ifa.if_ready_o), 32'(!stall));
        if (stall) begin
            tick;
            chk({tag, "_release_issue"}, 32'(ifa.ex_issue_o), 1);
            chk({tag, "_release_ifready"}, 32'(ifa.if_ready_o), 1);
        end
        tick;
        chk({tag, "_drained"}, 32'(ifa.id_valid_o), 0);
    endtask

    initial begin
        ifa.if_valid_i = 1'b0; ifa.if_instr_i = '0; ifa.ex_ready_i = 1'b1; ifa.branch_taken_i = 1'b0;
        ifb.if_valid_i = 1'b0; ifb.if_instr_i = '0; ifb.ex_ready_i = 1'b1; ifb.branch_taken_i = 1'b0;
        #12;
        chk("rst_state", 32'(ifa.state_o), 0);
        chk("rst_valid", 32'(ifa.id_valid_o), 0);
        chk("rst_instr", ifa.id_instr_o, NOP);
        chk("rst_ifready", 32'(ifa.if_ready_o), 1);
        chk("rst_issue", 32'(ifa.ex_issue_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: four addi stream at full rate
        ifa.if_valid_i = 1'b1;
        ifa.if_instr_i = addi[0];
        tick;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) ifa.if_valid_i = 1'b0;
            else ifa.if_instr_i = addi[k + 1];
            #1;
            chk($sformatf("stream%0d_instr", k), ifa.id_instr_o, addi[k]);
            chk($sformatf("stream%0d_issue", k), 32'(ifa.ex_issue_o), 1);
            chk($sformatf("stream%0d_ifready", k), 32'(ifa.if_ready_o), 1);
            tick;
        end
        chk("stream_drained", 32'(ifa.id_valid_o), 0);

        // 2 and 4: load-use stall of one cycle, rd=x0 and rs2-of-addi never stall
        pair_a("ll1", LW5, ADD, 1'b1);
        pair_a("rdx0", LW0, ADD00, 1'b0);
        pair_a("addi_rs2", LW5, ADDI5, 1'b0);

        // 3: LOAD_LATENCY=3 gives three stall cycles, state 0,1,1 then 0
        ifb.if_valid_i = 1'b1;
        ifb.if_instr_i = LW5;
        tick;
        ifb.if_instr_i = ADD;
        #1;
        chk("ll3_lw_issue", 32'(ifb.ex_issue_o), 1);
        tick;
        ifb.if_valid_i = 1'b0;
        #1;
        chk("ll3_s0_state", 32'(ifb.state_o), 0);
        chk("ll3_s0_issue", 32'(ifb.ex_issue_o), 0);
        chk("ll3_s0_ifready", 32'(ifb.if_ready_o), 0);
        tick;
        chk("ll3_s1_state", 32'(ifb.state_o), 1);
        chk("ll3_s1_issue", 32'(ifb.ex_issue_o), 0);
        chk("ll3_s1_ifready", 32'(ifb.if_ready_o), 0);
        tick;
        chk("ll3_s2_state", 32'(ifb.state_o), 1);
        chk("ll3_s2_issue", 32'(ifb.ex_issue_o), 0);
        tick;
        chk("ll3_run_state", 32'(ifb.state_o), 0);
        chk("ll3_run_issue", 32'(ifb.ex_issue_o), 1);
        chk("ll3_run_instr", ifb.id_instr_o, ADD);
        tick;
        chk("ll3_drained", 32'(ifb.id_valid_o), 0);

        // 5: branch beats a pending hazard, BRANCH_PENALTY=2 drops one fetch
        ifb.if_valid_i = 1'b1;
        ifb.if_instr_i = LW5;
        tick;
        ifb.if_instr_i = ADD;
        #1;
        chk("br_lw_issue", 32'(ifb.ex_issue_o), 1);
        tick;
        ifb.branch_taken_i = 1'b1;
        ifb.if_instr_i = addi[2];
        #1;
        chk("br_issue", 32'(ifb.ex_issue_o), 0);
        tick;
        ifb.branch_taken_i = 1'b0;
        ifb.if_instr_i = addi[3];
        #1;
        chk("br_valid", 32'(ifb.id_valid_o), 0);
        chk("br_flush_state", 32'(ifb.state_o), 2);
        chk("br_flush_ifready", 32'(ifb.if_ready_o), 1);
        tick;
        ifb.if_instr_i = addi[1];
        #1;
        chk("br_run_state", 32'(ifb.state_o), 0);
        chk("br_dropped_valid", 32'(ifb.id_valid_o), 0);
        chk("br_dropped_instr", ifb.id_instr_o, ADD);
        tick;
        ifb.if_valid_i = 1'b0;
        #1;
        chk("br_next_instr", ifb.id_instr_o, addi[1]);
        chk("br_next_issue", 32'(ifb.ex_issue_o), 1);
        tick;
        chk("br_drained", 32'(ifb.id_valid_o), 0);

        // 6a: EX back-pressure holds the IF/ID register
        ifb.if_valid_i = 1'b1;
        ifb.if_instr_i = addi[0];
        ifb.ex_ready_i = 1'b0;
        tick;
        ifb.if_instr_i = addi[1];
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_instr", i), ifb.id_instr_o, addi[0]);
            chk($sformatf("bp%0d_ifready", i), 32'(ifb.if_ready_o), 0);
            chk($sformatf("bp%0d_issue", i), 32'(ifb.ex_issue_o), 0);
            tick;
        end
        ifb.ex_ready_i = 1'b1;
        #1;
        chk("bp_release_issue", 32'(ifb.ex_issue_o), 1);
        chk("bp_release_ifready", 32'(ifb.if_ready_o), 1);
        tick;
        ifb.if_valid_i = 1'b0;
        #1;
        chk("bp_next_instr", ifb.id_instr_o, addi[1]);
        tick;

        // 6b: hazard with ex_ready_i=0 still stalls; branch in LSTALL goes to FLUSH
        ifb.if_valid_i = 1'b1;
        ifb.if_instr_i = LW5;
        tick;
        ifb.if_instr_i = ADD;
        #1;
        tick;
        ifb.if_valid_i = 1'b0;
        ifb.ex_ready_i = 1'b0;
        #1;
        chk("hzbp_issue", 32'(ifb.ex_issue_o), 0);
        tick;
        chk("hzbp_state", 32'(ifb.state_o), 1);
        ifb.branch_taken_i = 1'b1;
        tick;
        ifb.branch_taken_i = 1'b0;
        #1;
        chk("lstall_br_state", 32'(ifb.state_o), 2);
        chk("lstall_br_valid", 32'(ifb.id_valid_o), 0);
        tick;
        chk("lstall_br_run", 32'(ifb.state_o), 0);
        ifb.ex_ready_i = 1'b1;

        // 6c: asynchronous reset in the middle of LSTALL
        ifb.if_valid_i = 1'b1;
        ifb.if_instr_i = LW5;
        tick;
        ifb.if_instr_i = ADD;
        tick;
        ifb.if_valid_i = 1'b0;
        tick;
        chk("pre_rst_state", 32'(ifb.state_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(ifb.state_o), 0);
        chk("async_rst_valid", 32'(ifb.id_valid_o), 0);
        chk("async_rst_instr", ifb.id_instr_o, NOP);
        chk("async_rst_ifready", 32'(ifb.if_ready_o), 1);
        chk("async_rst_issue", 32'(ifb.ex_issue_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post_rst_state", 32'(ifb.state_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
